riot_bus_master: RTL and testbench
==================================

# riot_bus_master

Command-driven bus initiator for the RIOT-style peripheral bus. It turns single read, write and poll commands from an internal host into correctly strobed RIOT bus cycles, and returns read data through a valid/ready response channel. The block sits between test/debug or boot-sequencer logic and the RIOT, taking the place of the 6502 as bus driver when the CPU is not in use.

## Interface
- TIMEOUT_W, 16, width of the poll-attempt counter. A poll times out after 2^TIMEOUT_W unsuccessful attempts.
- CLK  in  1  clock. All state changes on the rising edge.
- RES  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_op  in  2  00 read, 01 write, 10 poll, 11 illegal.
- cmd_ram  in  1  1 selects RAM (BUS_RS_n=0); 0 selects I/O/timer space.
- cmd_addr  in  7  bus address.
- cmd_wdata  in  8  write data for a write; bit mask for a poll.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when high together with rsp_valid.
- rsp_data  out  8  read/poll data, or write-data echo for a write.
- rsp_err  out  1  poll timeout or illegal op.
- BUS_A  out  7  address to peripheral.
- BUS_DO  out  8  data to peripheral Din.
- BUS_DI  in  8  data from peripheral Dout.
- BUS_CS  out  1  chip select, active-high.
- BUS_CS_n  out  1  chip select, active-low.
- BUS_R_W_n  out  1  1 read, 0 write.
- BUS_RS_n  out  1  ROM/RAM select, active-low.

## Operation
- All outputs are registered.
- Bus idle values: BUS_CS=0, BUS_CS_n=1, BUS_R_W_n=1, BUS_RS_n=1, BUS_A=0, BUS_DO=0.
- FSM states:
  - IDLE: cmd_ready=1. On handshake, latch op, ram, addr and wdata, then go to ACCESS. An illegal op goes straight to RESP with err=1 and data=0, and no bus cycle runs.
  - ACCESS: for exactly one cycle, drive BUS_CS=1, BUS_CS_n=0, BUS_A=addr, BUS_RS_n=~ram, and BUS_R_W_n=0 only for a write. BUS_DO=wdata for a write, otherwise 0.
    - Write → RESP with data=wdata, err=0.
    - Read or poll → CAPTURE.
  - CAPTURE: bus is idle. Sample BUS_DI into the data register (the peripheral registers read data on the strobe edge).
    - Read → RESP.
    - Poll: if (BUS_DI & mask) != 0 → RESP with err=0.
    - Poll: else if the attempt counter is all-ones → RESP with err=1, keeping the last sampled data.
    - Poll: else increment the counter and return to ACCESS.
  - RESP: rsp_valid=1. rsp_data and rsp_err are held stable until rsp_ready. Then go to IDLE and clear the attempt counter.
- cmd_ready is 0 in every state except IDLE. Commands are never queued.
- The poll mask is 8 bits. A mask of 0 can never match, so it always ends in timeout after 2^TIMEOUT_W attempts.
- The counter is TIMEOUT_W bits wide, unsigned, and has no wrap: the all-ones check is made before incrementing.

## Timing
- Take the handshake edge as cycle 0.
- Write: strobe in cycle 1; rsp_valid from cycle 2.
- Read: strobe in cycle 1; capture in cycle 2; rsp_valid from cycle 3.
- Poll: one strobe every 2 cycles. A match on attempt n (counting from 1) gives rsp_valid at cycle 2n+1.
- Illegal op: rsp_valid from cycle 1.
- Back-to-back commands: next command accepted no earlier than the cycle after the rsp handshake. Minimum write-to-write period is 3 cycles.
- Reset values: every output at its idle value, cmd_ready=0 during the RES cycle (1 from the first cycle after reset), rsp_valid=0, rsp_data=0, rsp_err=0, FSM=IDLE, counter=0.
- Reset mid-operation aborts immediately. A strobe in progress is deasserted on that same edge, and no response is produced.

## Configuration
- RIOT_MASTER_POLL_EN defined: op 10 behaves as described above; the attempt counter and mask compare are present.
- RIOT_MASTER_POLL_EN undefined: op 10 is handled as illegal (err=1, data=0, no bus cycle, rsp_valid at cycle 1). The counter logic is removed and TIMEOUT_W is ignored.

## Test plan
- Write RAM 0x12 with 0xA5, then read RAM 0x12 → a single write strobe with RS_n=0, R_W_n=0, DO=0xA5; read rsp_data=0xA5, err=0, rsp_valid at cycle 3.
- I/O write addr 0x14 (timer /1) with 0x03, then poll addr 0x05 mask 0x80 against the RIOT model → match once the timer underflows; rsp_data bit7=1, err=0.
- TIMEOUT_W=3, poll a location reading 0x00 with mask 0x01 → exactly 8 strobes, then rsp_err=1, rsp_data=0x00.
- Read with rsp_ready held low for 5 cycles → rsp_valid/rsp_data stable, cmd_ready=0, no further strobes.
- RES asserted during a poll's ACCESS cycle → next cycle bus idle, rsp_valid=0, cmd_ready=1 after RES drops.
- cmd_op=11 → no strobe, rsp_valid at cycle 1, rsp_err=1. Also check op 10 gives the same response when built without RIOT_MASTER_POLL_EN.

Source files
------------

// File: rtl/riot_bus_master.sv
// ============================================================================
// riot_bus_master : command-driven RIOT bus initiator with valid/ready response
// Optional poll support: define RIOT_MASTER_POLL_EN
// Revision 1.0
// ============================================================================
`default_nettype none

module riot_bus_master #(
  parameter int TIMEOUT_W = 16
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       cmd_ram,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic [6:0] BUS_A,
  output logic [7:0] BUS_DO,
  input  logic [7:0] BUS_DI,
  output logic       BUS_CS,
  output logic       BUS_CS_n,
  output logic       BUS_R_W_n,
  output logic       BUS_RS_n
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic       ram_q, ram_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] data_q, data_d;
  logic       err_q, err_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       cs_q, cs_d;
  logic       cs_n_q, cs_n_d;
  logic       rw_n_q, rw_n_d;
  logic       rs_n_q, rs_n_d;
  logic [6:0] a_q, a_d;
  logic [7:0] do_q, do_d;
  logic       op_legal;

`ifdef RIOT_MASTER_POLL_EN
  localparam logic [1:0] OP_POLL = 2'b10;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  assign op_legal = (cmd_op == OP_READ) || (cmd_op == OP_WRITE) || (cmd_op == OP_POLL);
`else
  assign op_legal = (cmd_op == OP_READ) || (cmd_op == OP_WRITE);
  // TIMEOUT_W only sizes the poll counter, which this build does not contain.
  if (TIMEOUT_W < 1) begin : g_timeout_w_unused
  end
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ram_d   = ram_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    err_d   = err_q;
`ifdef RIOT_MASTER_POLL_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d    = cmd_op;
          ram_d   = cmd_ram;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          if (op_legal) begin
            state_d = ST_ACCESS;
          end else begin
            state_d = ST_RESP;
            data_d  = 8'h00;
            err_d   = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        if (op_q == OP_WRITE) begin
          state_d = ST_RESP;
          data_d  = wdata_q;
          err_d   = 1'b0;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        data_d  = BUS_DI;
        err_d   = 1'b0;
        state_d = ST_RESP;
`ifdef RIOT_MASTER_POLL_EN
        // All-ones is checked before incrementing, so the counter never wraps.
        if ((op_q == OP_POLL) && ((BUS_DI & wdata_q) == 8'h00)) begin
          if (&cnt_q) begin
            err_d = 1'b1;
          end else begin
            cnt_d   = cnt_q + TIMEOUT_W'(1);
            state_d = ST_ACCESS;
          end
        end
`endif
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
`ifdef RIOT_MASTER_POLL_EN
          cnt_d   = '0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so the strobe lines up with ACCESS.
    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    cs_d        = (state_d == ST_ACCESS);
    cs_n_d      = ~cs_d;
    a_d         = cs_d ? addr_d : 7'h00;
    rs_n_d      = ~(cs_d & ram_d);
    rw_n_d      = ~(cs_d && (op_d == OP_WRITE));
    do_d        = (cs_d && (op_d == OP_WRITE)) ? wdata_d : 8'h00;
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q     <= ST_IDLE;
      op_q        <= 2'b00;
      ram_q       <= 1'b0;
      addr_q      <= 7'h00;
      wdata_q     <= 8'h00;
      data_q      <= 8'h00;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      cs_q        <= 1'b0;
      cs_n_q      <= 1'b1;
      rw_n_q      <= 1'b1;
      rs_n_q      <= 1'b1;
      a_q         <= 7'h00;
      do_q        <= 8'h00;
`ifdef RIOT_MASTER_POLL_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ram_q       <= ram_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      data_q      <= data_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      cs_q        <= cs_d;
      cs_n_q      <= cs_n_d;
      rw_n_q      <= rw_n_d;
      rs_n_q      <= rs_n_d;
      a_q         <= a_d;
      do_q        <= do_d;
`ifdef RIOT_MASTER_POLL_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign BUS_CS    = cs_q;
  assign BUS_CS_n  = cs_n_q;
  assign BUS_R_W_n = rw_n_q;
  assign BUS_RS_n  = rs_n_q;
  assign BUS_A     = a_q;
  assign BUS_DO    = do_q;

endmodule

`default_nettype wire

// File: tb/tb_riot_bus_master.sv
// ============================================================================
// tb_riot_bus_master : directed self-checking bench with a small RIOT model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_riot_bus_master;

  logic       CLK = 1'b0;
  logic       RES;
  logic       cmd_valid, cmd_ready, cmd_ram, rsp_valid, rsp_ready, rsp_err;
  logic [1:0] cmd_op;
  logic [6:0] cmd_addr, BUS_A;
  logic [7:0] cmd_wdata, rsp_data, BUS_DO, BUS_DI;
  logic       BUS_CS, BUS_CS_n, BUS_R_W_n, BUS_RS_n;

  int tests = 0;
  int fails = 0;
  int strobes = 0;

  logic [7:0] mem [0:127];
  logic [7:0] tmr;
  logic       flag;

  logic [18:0] bus_w;
  assign bus_w = {BUS_CS, BUS_CS_n, BUS_R_W_n, BUS_RS_n, BUS_A, BUS_DO};
  localparam logic [18:0] BUS_IDLE = {1'b0, 1'b1, 1'b1, 1'b1, 7'h00, 8'h00};

  riot_bus_master #(.TIMEOUT_W(3)) dut (
    .CLK(CLK), .RES(RES),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_ram(cmd_ram), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .BUS_A(BUS_A), .BUS_DO(BUS_DO), .BUS_DI(BUS_DI), .BUS_CS(BUS_CS),
    .BUS_CS_n(BUS_CS_n), .BUS_R_W_n(BUS_R_W_n), .BUS_RS_n(BUS_RS_n)
  );

  always #5 CLK = ~CLK;

  // Peripheral: RAM plus a down-counting timer at I/O 0x14 whose underflow flag reads at I/O 0x05 bit 7.
  always @(posedge CLK) begin
    if (tmr != 8'h00) begin
      tmr <= tmr - 8'h01;
      if (tmr == 8'h01) flag <= 1'b1;
    end
    if (BUS_CS === 1'b1) begin
      strobes <= strobes + 1;
      if (BUS_R_W_n === 1'b0) begin
        if (BUS_RS_n === 1'b0) mem[BUS_A] <= BUS_DO;
        else if (BUS_A == 7'h14) begin tmr <= BUS_DO; flag <= 1'b0; end
      end else begin
        BUS_DI <= (BUS_RS_n === 1'b0) ? mem[BUS_A] : ((BUS_A == 7'h05) ? {flag, 7'h00} : 8'h00);
      end
    end
  end

  // Issues one command; returns at the sample point of cycle 1.
  task automatic send(input logic [1:0] op, input logic ram, input logic [6:0] addr, input logic [7:0] wd);
    int k;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 50) begin @(negedge CLK); k++; end
    if (cmd_ready !== 1'b1) begin
      tests++; fails++; $display("FAIL send_ready_timeout: cmd_ready got %b, expected 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_ram = ram; cmd_addr = addr; cmd_wdata = wd;
    @(posedge CLK); @(negedge CLK);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    RES = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    @(posedge CLK); @(posedge CLK); @(negedge CLK);
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL rst_cmd_ready: got %b, expected 0", cmd_ready); end
    tests++; if ({rsp_valid, rsp_err, rsp_data} !== 10'h000) begin fails++; $display("FAIL rst_rsp: got %h, expected 000", {rsp_valid, rsp_err, rsp_data}); end
    tests++; if (bus_w !== BUS_IDLE) begin fails++; $display("FAIL rst_bus: got %h, expected %h", bus_w, BUS_IDLE); end
    RES = 1'b0;
    @(negedge CLK);
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_ready_after: got %b, expected 1", cmd_ready); end
  endtask

  task automatic test_write;
    int base;
    base = strobes;
    send(2'b01, 1'b1, 7'h12, 8'hA5);
    tests++; if (bus_w !== {4'b1000, 7'h12, 8'hA5}) begin fails++; $display("FAIL wr_strobe: got %h, expected %h", bus_w, {4'b1000, 7'h12, 8'hA5}); end
    tests++; if ({cmd_ready, rsp_valid} !== 2'b00) begin fails++; $display("FAIL wr_c1_flags: got %b, expected 00", {cmd_ready, rsp_valid}); end
    @(negedge CLK);
    tests++; if (bus_w !== BUS_IDLE) begin fails++; $display("FAIL wr_c2_bus: got %h, expected %h", bus_w, BUS_IDLE); end
    tests++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 8'hA5}) begin fails++; $display("FAIL wr_rsp: got %h, expected %h", {rsp_valid, rsp_err, rsp_data}, {2'b10, 8'hA5}); end
    tests++; if (strobes - base !== 1) begin fails++; $display("FAIL wr_strobes: got %0d, expected 1", strobes - base); end
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    tests++; if ({rsp_valid, cmd_ready} !== 2'b01) begin fails++; $display("FAIL wr_after_hs: got %b, expected 01", {rsp_valid, cmd_ready}); end
  endtask

  task automatic test_read_stall;
    int base;
    base = strobes;
    send(2'b00, 1'b1, 7'h12, 8'h00);
    tests++; if (bus_w !== {4'b1010, 7'h12, 8'h00}) begin fails++; $display("FAIL rd_strobe: got %h, expected %h", bus_w, {4'b1010, 7'h12, 8'h00}); end
    @(negedge CLK);
    tests++; if ({rsp_valid, bus_w} !== {1'b0, BUS_IDLE}) begin fails++; $display("FAIL rd_c2: got %h, expected %h", {rsp_valid, bus_w}, {1'b0, BUS_IDLE}); end
    @(negedge CLK);
    tests++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 8'hA5}) begin fails++; $display("FAIL rd_rsp_c3: got %h, expected %h", {rsp_valid, rsp_err, rsp_data}, {2'b10, 8'hA5}); end
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      tests++; if ({rsp_valid, rsp_err, rsp_data, cmd_ready, BUS_CS} !== {2'b10, 8'hA5, 2'b00}) begin
        fails++; $display("FAIL rd_stall_%0d: got %h, expected %h", i, {rsp_valid, rsp_err, rsp_data, cmd_ready, BUS_CS}, {2'b10, 8'hA5, 2'b00});
      end
    end
    tests++; if (strobes - base !== 1) begin fails++; $display("FAIL rd_strobes: got %0d, expected 1", strobes - base); end
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rd_release: got %b, expected 0", rsp_valid); end
  endtask

  task automatic test_illegal(input logic [1:0] op);
    int base;
    base = strobes;
    send(op, 1'b1, 7'h12, 8'hFF);
    tests++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b11, 8'h00}) begin fails++; $display("FAIL ill_rsp_op%0d: got %h, expected %h", op, {rsp_valid, rsp_err, rsp_data}, {2'b11, 8'h00}); end
    tests++; if ({cmd_ready, bus_w} !== {1'b0, BUS_IDLE}) begin fails++; $display("FAIL ill_bus_op%0d: got %h, expected %h", op, {cmd_ready, bus_w}, {1'b0, BUS_IDLE}); end
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    tests++; if (strobes - base !== 0) begin fails++; $display("FAIL ill_strobes_op%0d: got %0d, expected 0", op, strobes - base); end
  endtask

  task automatic test_back_to_back;
    rsp_ready = 1'b1;
    send(2'b01, 1'b1, 7'h20, 8'h11);
    @(negedge CLK);
    tests++; if ({cmd_ready, rsp_valid, rsp_data} !== {2'b01, 8'h11}) begin fails++; $display("FAIL b2b_c2: got %h, expected %h", {cmd_ready, rsp_valid, rsp_data}, {2'b01, 8'h11}); end
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_ram = 1'b1; cmd_addr = 7'h21; cmd_wdata = 8'h22;
    @(negedge CLK);
    tests++; if ({cmd_ready, rsp_valid, BUS_CS} !== 3'b100) begin fails++; $display("FAIL b2b_c3: got %b, expected 100", {cmd_ready, rsp_valid, BUS_CS}); end
    @(negedge CLK);
    cmd_valid = 1'b0;
    tests++; if (bus_w !== {4'b1000, 7'h21, 8'h22}) begin fails++; $display("FAIL b2b_strobe2: got %h, expected %h", bus_w, {4'b1000, 7'h21, 8'h22}); end
    @(negedge CLK);
    tests++; if ({rsp_valid, rsp_data} !== {1'b1, 8'h22}) begin fails++; $display("FAIL b2b_rsp2: got %h, expected %h", {rsp_valid, rsp_data}, {1'b1, 8'h22}); end
    @(negedge CLK);
    rsp_ready = 1'b0;
    tests++; if ({mem[32], mem[33]} !== 16'h1122) begin fails++; $display("FAIL b2b_mem: got %h, expected 1122", {mem[32], mem[33]}); end
  endtask

  task automatic test_reset_mid(input logic [1:0] op);
    int base;
    send(op, 1'b0, 7'h00, 8'h01);
    tests++; if (BUS_CS !== 1'b1) begin fails++; $display("FAIL rmid_strobe: got %b, expected 1", BUS_CS); end
    RES = 1'b1;
    @(negedge CLK);
    RES = 1'b0;
    tests++; if ({rsp_valid, cmd_ready, bus_w} !== {2'b00, BUS_IDLE}) begin fails++; $display("FAIL rmid_abort: got %h, expected %h", {rsp_valid, cmd_ready, bus_w}, {2'b00, BUS_IDLE}); end
    base = strobes;
    @(negedge CLK);
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready: got %b, expected 1", cmd_ready); end
    repeat (4) @(negedge CLK);
    tests++; if ({rsp_valid, 8'(strobes - base)} !== 9'h000) begin fails++; $display("FAIL rmid_quiet: got %h, expected 000", {rsp_valid, 8'(strobes - base)}); end
  endtask

`ifdef RIOT_MASTER_POLL_EN
  task automatic test_poll_match;
    int base;
    base = strobes;
    send(2'b10, 1'b1, 7'h12, 8'h01);
    tests++; if (bus_w !== {4'b1010, 7'h12, 8'h00}) begin fails++; $display("FAIL pm_strobe: got %h, expected %h", bus_w, {4'b1010, 7'h12, 8'h00}); end
    @(negedge CLK);
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL pm_c2: got %b, expected 0", rsp_valid); end
    @(negedge CLK);
    tests++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 8'hA5}) begin fails++; $display("FAIL pm_rsp: got %h, expected %h", {rsp_valid, rsp_err, rsp_data}, {2'b10, 8'hA5}); end
    tests++; if (strobes - base !== 1) begin fails++; $display("FAIL pm_strobes: got %0d, expected 1", strobes - base); end
    rsp_ready = 1'b1; @(negedge CLK); rsp_ready = 1'b0;
  endtask

  task automatic test_poll_timeout;
    int base;
    base = strobes;
    send(2'b10, 1'b0, 7'h00, 8'h01);
    for (int c = 2; c <= 17; c++) begin
      @(negedge CLK);
      if (c == 15) begin
        tests++; if (BUS_CS !== 1'b1) begin fails++; $display("FAIL pt_strobe8: got %b, expected 1", BUS_CS); end
      end
      if (c == 16) begin
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL pt_early: got %b, expected 0", rsp_valid); end
      end
    end
    tests++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b11, 8'h00}) begin fails++; $display("FAIL pt_rsp: got %h, expected %h", {rsp_valid, rsp_err, rsp_data}, {2'b11, 8'h00}); end
    tests++; if (strobes - base !== 8) begin fails++; $display("FAIL pt_strobes: got %0d, expected 8", strobes - base); end
    rsp_ready = 1'b1; @(negedge CLK); rsp_ready = 1'b0;
  endtask

  task automatic test_poll_timer;
    int base, k;
    rsp_ready = 1'b1;
    send(2'b01, 1'b0, 7'h14, 8'h03);
    @(negedge CLK);
    base = strobes;
    send(2'b10, 1'b0, 7'h05, 8'h80);
    k = 0;
    while (rsp_valid !== 1'b1 && k < 40) begin @(negedge CLK); k++; end
    tests++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 8'h80}) begin fails++; $display("FAIL ptm_rsp: got %h, expected %h", {rsp_valid, rsp_err, rsp_data}, {2'b10, 8'h80}); end
    tests++; if (strobes - base !== 2) begin fails++; $display("FAIL ptm_attempts: got %0d, expected 2", strobes - base); end
    @(negedge CLK);
    rsp_ready = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    tmr = 8'h00; flag = 1'b0; BUS_DI = 8'h00;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_ram = 1'b0; cmd_addr = 7'h00; cmd_wdata = 8'h00;
    rsp_ready = 1'b0; RES = 1'b1;
    test_reset;
    test_write;
    test_read_stall;
    test_illegal(2'b11);
    test_back_to_back;
`ifdef RIOT_MASTER_POLL_EN
    test_poll_match;
    test_poll_timeout;
    test_poll_timer;
    test_reset_mid(2'b10);
`else
    test_illegal(2'b10);
    test_reset_mid(2'b00);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
